wb_write_arbiter: RTL and testbench

//  Shares the single general-purpose register file write port between two writeback requesters:

---
 rtl/wb_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Shares the single register file write port between two writeback
// requesters. Port A carries single-cycle ALU results, and port B carries
// load results from the multi-cycle memory path.
//
// Arbitration:
//   - A has priority.
//   - B is forced through once it has been blocked for STARVE_LIMIT
//     consecutive cycles.
//
// The winner is registered into one output stage that drives the register
// file write. Writes to register 0 are accepted but never enabled. A pending
// bitmap shows every register that has a write in flight, for hazard
// detection.
//
// Optional feature macro: WB_FWD_EN. When defined, it adds two combinational
// forwarding read ports that expose the output-stage value before the
// register file commits it.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   a_valid/a_ready      port A handshake (ready is combinational)
//   a_addr/a_data        port A destination register and data
//   b_valid/b_ready      port B handshake (ready is combinational)
//   b_addr/b_data        port B destination register and data
//   gp_we                register file write enable (output stage)
//   write_addr           register file write address (output stage)
//   write_data           register file write data (output stage)
//   pending              one bit per register with a write in flight
//   [WB_FWD_EN] rd_addr1/2 in; fwd_hit1/2 and fwd_data1/2 out
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]    rd_addr1,
    input  logic [ADDR_W-1:0]    rd_addr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DATA_W-1:0]    fwd_data1,
    output logic [DATA_W-1:0]    fwd_data2,
`endif
    output logic                 gp_we,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [DATA_W-1:0]    write_data,
    output logic [2**ADDR_W-1:0] pending
);

    // State holds the owner of the output stage for the current cycle.
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Grant decision. Both readies are held low during reset so that
    // nothing is accepted while the output stage is being cleared.
    always_comb begin
        next_state = IDLE;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        if (!reset) begin
            if (b_valid && (!a_valid || starve_cnt >= LIMIT)) begin
                next_state = GNT_B;
                b_ready    = 1'b1;
                sel_addr   = b_addr;
                sel_data   = b_data;
            end else if (a_valid) begin
                next_state = GNT_A;
                a_ready    = 1'b1;
                sel_addr   = a_addr;
                sel_data   = a_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Counts consecutive cycles in which B waited without being served.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (!b_valid || b_ready)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // The output stage loads on every grant. When nothing is granted, the
    // address and data hold their last values and only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_addr <= '0;
            write_data <= '0;
        end else if (next_state != IDLE) begin
            write_addr <= sel_addr;
            write_data <= sel_data;
        end
    end

    // The enable is decoded purely from output-stage registers. A register-0
    // write occupies the stage but never reaches the register file.
    assign gp_we = (state != IDLE) && (write_addr != '0);

    always_comb begin
        pending = '0;
        for (int i = 1; i < 2**ADDR_W; i++) begin
            pending[i] = (a_valid && a_addr == ADDR_W'(i)) ||
                         (b_valid && b_addr == ADDR_W'(i)) ||
                         (gp_we && write_addr == ADDR_W'(i));
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit1  = gp_we && (write_addr == rd_addr1) && (rd_addr1 != '0);
    assign fwd_hit2  = gp_we && (write_addr == rd_addr2) && (rd_addr2 != '0);
    assign fwd_data1 = fwd_hit1 ? write_data : '0;
    assign fwd_data2 = fwd_hit2 ? write_data : '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Directed, table-driven bench for wb_write_arbiter with default parameters
// (DATA_W=32, ADDR_W=5, STARVE_LIMIT=4).
//
// Each table row holds the requester inputs for one cycle together with the
// expected readies, output stage and pending bitmap seen during that cycle.
// Hand-written sequences cover reset behaviour and, when the design is built
// with WB_FWD_EN, the forwarding ports.
// -----------------------------------------------------------------------------
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        gp_we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;
`ifdef WB_FWD_EN
    logic [4:0]  rd_addr1, rd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
`ifdef WB_FWD_EN
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2),
`endif
        .gp_we      (gp_we),
        .write_addr (write_addr),
        .write_data (write_data),
        .pending    (pending)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        gp;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pend;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // Columns: a_valid a_addr a_data | b_valid b_addr b_data |
        //          a_ready b_ready gp_we write_addr write_data pending
        vt[0]  = '{0, 0,  0,           0, 0, 0,           0, 0, 0, 0, 0,           32'h0};
        vt[1]  = '{1, 3,  32'h12345678, 0, 0, 0,          1, 0, 0, 0, 0,           32'h8};
        vt[2]  = '{0, 0,  0,           0, 0, 0,           0, 0, 1, 3, 32'h12345678, 32'h8};
        vt[3]  = '{0, 0,  0,           1, 0, 32'hFFFFFFFF, 0, 1, 0, 3, 32'h12345678, 32'h0};
        vt[4]  = '{0, 0,  0,           0, 0, 0,           0, 0, 0, 0, 32'hFFFFFFFF, 32'h0};
        vt[5]  = '{1, 7,  32'hAAAA,    1, 7, 32'hBBBB,    1, 0, 0, 0, 32'hFFFFFFFF, 32'h80};
        vt[6]  = '{0, 0,  0,           1, 7, 32'hBBBB,    0, 1, 1, 7, 32'hAAAA,     32'h80};
        vt[7]  = '{0, 0,  0,           0, 0, 0,           0, 0, 1, 7, 32'hBBBB,     32'h80};
        vt[8]  = '{0, 0,  0,           0, 0, 0,           0, 0, 0, 7, 32'hBBBB,     32'h0};
        vt[9]  = '{1, 10, 32'hA10,     1, 2, 32'hB2,      1, 0, 0, 7, 32'hBBBB,     32'h404};
        vt[10] = '{1, 11, 32'hA11,     1, 2, 32'hB2,      1, 0, 1, 10, 32'hA10,     32'hC04};
        vt[11] = '{1, 12, 32'hA12,     1, 2, 32'hB2,      1, 0, 1, 11, 32'hA11,     32'h1804};
        vt[12] = '{1, 13, 32'hA13,     1, 2, 32'hB2,      1, 0, 1, 12, 32'hA12,     32'h3004};
        vt[13] = '{1, 14, 32'hA14,     1, 2, 32'hB2,      0, 1, 1, 13, 32'hA13,     32'h6004};
        vt[14] = '{1, 14, 32'hA14,     0, 0, 0,           1, 0, 1, 2, 32'hB2,       32'h4004};
        vt[15] = '{1, 15, 32'hA15,     1, 2, 32'hB2,      1, 0, 1, 14, 32'hA14,     32'hC004};
        vt[16] = '{0, 0,  0,           1, 2, 32'hB2,      0, 1, 1, 15, 32'hA15,     32'h8004};
        vt[17] = '{0, 0,  0,           0, 0, 0,           0, 0, 1, 2, 32'hB2,       32'h4};
        vt[18] = '{0, 0,  0,           0, 0, 0,           0, 0, 0, 2, 32'hB2,       32'h0};

        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
`ifdef WB_FWD_EN
        rd_addr1 = 0; rd_addr2 = 0;
`endif
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        // Readies must stay low while reset is held, even with both requesting.
        a_valid = 1; a_addr = 4; b_valid = 1; b_addr = 6;
        #3;
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        chk("rst_gp_we", 32'(gp_we), 32'h0);
        chk("rst_write_addr", 32'(write_addr), 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        a_valid = 0; a_addr = 0; b_valid = 0; b_addr = 0;
        #1;
        chk("rst_pending", pending, 32'h0);
        @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 19; i++) begin
            a_valid = vt[i].av; a_addr = vt[i].aa; a_data = vt[i].ad;
            b_valid = vt[i].bv; b_addr = vt[i].ba; b_data = vt[i].bd;
            #3;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vt[i].ar));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vt[i].br));
            chk($sformatf("v%0d_gp_we", i), 32'(gp_we), 32'(vt[i].gp));
            chk($sformatf("v%0d_write_addr", i), 32'(write_addr), 32'(vt[i].wa));
            chk($sformatf("v%0d_write_data", i), write_data, vt[i].wd);
            chk($sformatf("v%0d_pending", i), pending, vt[i].pend);
            @(posedge clk);
            #1;
        end

        // Reset arriving while an accepted write sits in the output stage.
        a_valid = 1; a_addr = 5; a_data = 32'hDEAD;
        #3;
        chk("mid_a_ready", 32'(a_ready), 32'h1);
        @(posedge clk);
        #1;
        a_valid = 0; a_addr = 0; a_data = 0;
        reset = 1;
        #3;
        chk("mid_inflight_we", 32'(gp_we), 32'h1);
        chk("mid_inflight_addr", 32'(write_addr), 32'h5);
        @(posedge clk);
        #1;
        chk("mid_post_gp_we", 32'(gp_we), 32'h0);
        chk("mid_post_pending", pending, 32'h0);
        chk("mid_post_addr", 32'(write_addr), 32'h0);
        reset = 0;
        @(posedge clk);
        #1;
        chk("mid_idle_gp_we", 32'(gp_we), 32'h0);

`ifdef WB_FWD_EN
        a_valid = 1; a_addr = 9; a_data = 32'hCAFE;
        @(posedge clk);
        #1;
        a_valid = 0; a_addr = 0; a_data = 0;
        rd_addr1 = 9; rd_addr2 = 0;
        #2;
        chk("fwd_hit1", 32'(fwd_hit1), 32'h1);
        chk("fwd_data1", fwd_data1, 32'hCAFE);
        chk("fwd_hit2", 32'(fwd_hit2), 32'h0);
        chk("fwd_data2", fwd_data2, 32'h0);
        rd_addr2 = 8;
        #1;
        chk("fwd_hit2_other", 32'(fwd_hit2), 32'h0);
        @(posedge clk);
        #1;
        chk("fwd_hit1_idle", 32'(fwd_hit1), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
